// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, d = a - b.
// One bit per clock, LSB first, through a single full-subtractor cell with a
// registered borrow. A start/busy/done handshake sequences operations.
// Optional feature: define SERSUB_OVF_EN to add the signed-overflow flag ovf.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
`ifdef SERSUB_OVF_EN
   output logic             bo,
   output logic             ovf
`else
   output logic             bo
`endif
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;
   logic   load, step, last;

   logic [WIDTH-1:0] a_sr, b_sr;
   logic [WIDTH-2:0] res_sr;     // bits produced so far, newest at the top
   logic [CNT_W-1:0] cnt;
   logic             br;
   logic             ai, bi, diff, br_next;
   logic [WIDTH-1:0] res_full;   // result including the bit produced this cycle

`ifdef SERSUB_OVF_EN
   logic             a_msb, b_msb;
`endif

   // Single full-subtractor cell working on the operand LSBs and the borrow
   always_comb begin
      ai       = a_sr[0];
      bi       = b_sr[0];
      diff     = ai ^ bi ^ br;
      br_next  = (~ai & bi) | (~(ai ^ bi) & br);
      res_full = {diff, res_sr};
   end

   // Next-state and sequencing strobes
   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == LAST_CNT) begin
               last       = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Operand and partial-result shift registers; contents are don't-care
   // outside RUN, so they carry no reset
   always_ff @(posedge clk) begin
      if (load) begin
         a_sr <= a;
         b_sr <= b;
`ifdef SERSUB_OVF_EN
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
`endif
      end else if (step) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         res_sr <= res_full[WIDTH-1:1];
      end
   end

   // Borrow, bit counter and handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br   <= 1'b0;
         cnt  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         if (load) begin
            br  <= 1'b0;
            cnt <= '0;
         end else if (step) begin
            br  <= br_next;
            cnt <= cnt + 1'b1;
         end
         busy <= (state_next == RUN);
         done <= last;
      end
   end

   // Visible result: updated only when the final bit is produced
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d  <= '0;
         bo <= 1'b0;
`ifdef SERSUB_OVF_EN
         ovf <= 1'b0;
`endif
      end else if (last) begin
         d  <= res_full;
         bo <= br_next;
`ifdef SERSUB_OVF_EN
         ovf <= (a_msb != b_msb) && (diff != a_msb);
`endif
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized bench for serial_subtractor
// (WIDTH=8) with an arithmetic reference model.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   logic       busy, done, bo;
   logic [7:0] d;
`ifdef SERSUB_OVF_EN
   logic       ovf;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] prev_d = 8'h00;
   logic       prev_bo = 1'b0;
   logic       prev_ovf = 1'b0;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .d     (d),
`ifdef SERSUB_OVF_EN
      .bo    (bo),
      .ovf   (ovf)
`else
      .bo    (bo)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer arithmetic on the operands
   task automatic model(input logic [7:0] av, input logic [7:0] bv,
                        output logic [7:0] ed, output logic ebo, output logic eovf);
      int ud, sd;
      ud   = int'(av) - int'(bv);
      sd   = int'($signed(av)) - int'($signed(bv));
      ed   = 8'(ud & 255);
      ebo  = (ud < 0);
      eovf = (sd < -128) || (sd > 127);
   endtask

   task automatic chk_result(input string tag, input logic [7:0] av, input logic [7:0] bv);
      logic [7:0] ed;
      logic       ebo, eovf;
      model(av, bv, ed, ebo, eovf);
      chk({tag, ".d"}, 32'(d), 32'(ed));
      chk({tag, ".bo"}, 32'(bo), 32'(ebo));
`ifdef SERSUB_OVF_EN
      chk({tag, ".ovf"}, 32'(ovf), 32'(eovf));
`endif
      prev_d   = ed;
      prev_bo  = ebo;
      prev_ovf = eovf;
   endtask

   // One isolated operation; with noise, a/b/start are scrambled during RUN
   task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv, input bit noise);
      a = av; b = bv; start = 1'b1;
      tick();
      chk({tag, ".busy_e0"}, 32'(busy), 32'd1);
      chk({tag, ".done_e0"}, 32'(done), 32'd0);
      start = 1'b0;
      for (int i = 1; i < 8; i++) begin
         if (noise) begin
            a = 8'($urandom); b = 8'($urandom); start = 1'($urandom);
         end
         tick();
         chk({tag, ".busy_run"}, 32'(busy), 32'd1);
         chk({tag, ".done_run"}, 32'(done), 32'd0);
         chk({tag, ".d_hold"}, 32'(d), 32'(prev_d));
         chk({tag, ".bo_hold"}, 32'(bo), 32'(prev_bo));
      end
      tick();
      start = 1'b0;
      chk({tag, ".done_e8"}, 32'(done), 32'd1);
      chk({tag, ".busy_e8"}, 32'(busy), 32'd0);
      chk_result(tag, av, bv);
      tick();
      chk({tag, ".done_e9"}, 32'(done), 32'd0);
      chk({tag, ".busy_e9"}, 32'(busy), 32'd0);
      chk({tag, ".d_after"}, 32'(d), 32'(prev_d));
   endtask

   initial begin
      logic [7:0] ops_a [4];
      logic [7:0] ops_b [4];

      // Reset held for 3 cycles, then idle with start low
      #2 rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("reset.busy", 32'(busy), 32'd0);
         chk("reset.done", 32'(done), 32'd0);
         chk("reset.d", 32'(d), 32'd0);
         chk("reset.bo", 32'(bo), 32'd0);
`ifdef SERSUB_OVF_EN
         chk("reset.ovf", 32'(ovf), 32'd0);
`endif
      end

      // Directed cases
      run_op("basic", 8'h5A, 8'h21, 1'b0);
      chk("basic.d_const", 32'(d), 32'h39);
      run_op("borrow", 8'h10, 8'h20, 1'b0);
      chk("borrow.d_const", 32'(d), 32'hF0);
      chk("borrow.bo_const", 32'(bo), 32'd1);
      run_op("equal_ff", 8'hFF, 8'hFF, 1'b0);
      chk("equal_ff.d_const", 32'(d), 32'h00);
      run_op("zero_minus_one", 8'h00, 8'h01, 1'b0);
      chk("zero_minus_one.d_const", 32'(d), 32'hFF);
      run_op("ovf_neg", 8'h80, 8'h01, 1'b0);
      run_op("ovf_pos", 8'h7F, 8'hFF, 1'b0);
      run_op("no_ovf", 8'h05, 8'h03, 1'b0);

      // Random operands with a/b/start scrambled during RUN
      for (int k = 0; k < 10; k++)
         run_op("random", 8'($urandom), 8'($urandom), 1'b1);

      // Back-to-back with start held high: done every 9 cycles
      for (int k = 0; k < 4; k++) begin
         ops_a[k] = 8'($urandom);
         ops_b[k] = 8'($urandom);
      end
      a = ops_a[0]; b = ops_b[0]; start = 1'b1;
      tick();
      chk("b2b.busy_e0", 32'(busy), 32'd1);
      for (int k = 0; k < 4; k++) begin
         for (int i = 1; i < 8; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            tick();
            chk("b2b.busy_run", 32'(busy), 32'd1);
            chk("b2b.done_run", 32'(done), 32'd0);
         end
         tick();
         chk("b2b.done", 32'(done), 32'd1);
         chk("b2b.busy_done", 32'(busy), 32'd0);
         chk_result("b2b", ops_a[k], ops_b[k]);
         if (k < 3) begin
            a = ops_a[k+1]; b = ops_b[k+1];
            tick();
            chk("b2b.restart_busy", 32'(busy), 32'd1);
            chk("b2b.restart_done", 32'(done), 32'd0);
         end else begin
            start = 1'b0;
            tick();
            chk("b2b.end_busy", 32'(busy), 32'd0);
            chk("b2b.end_done", 32'(done), 32'd0);
         end
      end

      // Abort mid-operation with reset, then a fresh operation
      run_op("pre_abort", 8'hC3, 8'h11, 1'b0);
      a = 8'h77; b = 8'h22; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      chk("abort.busy", 32'(busy), 32'd0);
      chk("abort.done", 32'(done), 32'd0);
      chk("abort.d", 32'(d), 32'd0);
      chk("abort.bo", 32'(bo), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("abort.no_done", 32'(done), 32'd0);
      end
      prev_d = 8'h00; prev_bo = 1'b0; prev_ovf = 1'b0;
      run_op("post_abort", 8'h03, 8'h01, 1'b0);
      chk("post_abort.d_const", 32'(d), 32'h02);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
